// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory fetch bus between if_prefetch_stage (master) and the
// instruction memory (slave). One request outstanding, in-order responses.
interface if_prefetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with an in-order prefetch queue.
// Decouples variable instruction-memory latency from ID; a taken branch
// flushes the queue and drops any in-flight fetch.
// Optional feature: define IF_PERF_CNT_EN to add perf_fetched/perf_flushed.
module if_prefetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 Branch_taken,
    input  logic [ADDR_W-1:0]    BranchAddr,
    if_prefetch_stage_if.master  mem,
    output logic                 valid,
    output logic [ADDR_W-1:0]    PC,
    output logic [DATA_W-1:0]    Instruction
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_flushed
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fpc_q;
    logic [ADDR_W-1:0] req_pc_q;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic push;
    logic pop;

    // The outstanding fetch is only issued while the queue has room, so the
    // eventual push can never overflow even though in-flight data is not counted.
    assign mem.mem_req  = rst & (state_q == S_REQ) & (count_q < CNT_W'(DEPTH)) & ~Branch_taken;
    assign mem.mem_addr = fpc_q;

    assign push = (state_q == S_WAIT) & mem.mem_rvalid & ~Branch_taken;
    assign pop  = valid & ~freeze & ~Branch_taken;

    assign valid       = (count_q != '0);
    assign PC          = valid ? pc_mem[rd_ptr_q]   : '0;
    assign Instruction = valid ? data_mem[rd_ptr_q] : '0;

    // Fetch sequencer: issue one request, then wait for (or drop) its response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_REQ;
            fpc_q   <= RESET_PC;
        end else begin
            if (Branch_taken) begin
                fpc_q <= BranchAddr;
            end
            unique case (state_q)
                S_REQ: begin
                    if (mem.mem_req) begin
                        req_pc_q <= fpc_q;
                        fpc_q    <= fpc_q + STEP;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rvalid) begin
                        state_q <= S_REQ;
                    end else if (Branch_taken) begin
                        state_q <= S_DROP;
                    end
                end
                S_DROP: begin
                    // The owed response retires this state even if another
                    // branch arrives with it; otherwise we would wait forever.
                    if (mem.mem_rvalid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    // Queue pointer/occupancy next-state; a branch empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Branch_taken) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; each entry holds the fall-through PC and the instruction.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= req_pc_q + STEP;
            data_mem[wr_ptr_q] <= mem.mem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic        inflight_lost;

    // A flush in WAIT loses the in-flight response; DROP was already counted.
    assign inflight_lost = Branch_taken & (state_q == S_WAIT);

    // Performance counters: pushes and discarded work, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (Branch_taken) begin
                perf_flushed_q <= perf_flushed_q + 32'(count_q) + 32'(inflight_lost);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage against a queue-based reference model
// and a single-slot instruction memory with 1..4 cycle latency.
module tb_if_prefetch_stage;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic        valid;
    logic [31:0] PC;
    logic [31:0] Instruction;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    if_prefetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

    if_prefetch_stage #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .mem          (mem_bus.master),
        .valid        (valid),
        .PC           (PC),
        .Instruction  (Instruction)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // Reference model: queue contents, next fetch address, and the one fetch
    // that may be owed by memory (and whether it is to be thrown away).
    ent_t        q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_req_pc;
    bit          m_owed;
    bit          m_discard;
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;

    // Memory model: at most one pending response.
    bit          pend;
    int          wcnt;
    logic [31:0] pend_data;

    bit armed;
    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit f, input bit b, input logic [31:0] ba);
        bit          rv;
        bit          was_valid;
        bit          exp_req;
        logic [31:0] rd;
        @(negedge clk);
        rv = pend && (wcnt == 0);
        rd = rv ? pend_data : $urandom;
        rst                = r;
        freeze             = f;
        Branch_taken       = b;
        BranchAddr         = ba;
        mem_bus.mem_rvalid = rv;
        mem_bus.mem_rdata  = rd;
        #1;
        was_valid = (q.size() != 0);
        exp_req   = r && !m_owed && (q.size() < DEPTH) && !b;
        if (armed) begin
            chk("valid", 64'(valid), 64'(was_valid));
            chk("pc", 64'(PC), was_valid ? 64'(q[0].pc) : 64'd0);
            chk("instr", 64'(Instruction), was_valid ? 64'(q[0].ins) : 64'd0);
            chk("mem_req", 64'(mem_bus.mem_req), 64'(exp_req));
            if (exp_req) begin
                chk("mem_addr", 64'(mem_bus.mem_addr), 64'(m_fpc));
            end
`ifdef IF_PERF_CNT_EN
            chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            chk("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
        end

        // Reference update at the coming rising edge.
        if (!r) begin
            q.delete();
            m_fpc     = RESET_PC;
            m_owed    = 0;
            m_discard = 0;
            m_fetched = '0;
            m_flushed = '0;
        end else if (b) begin
            m_flushed = m_flushed + 32'(q.size()) + ((m_owed && !m_discard) ? 32'd1 : 32'd0);
            q.delete();
            m_fpc = ba;
            if (m_owed) begin
                if (rv) begin
                    m_owed    = 0;
                    m_discard = 0;
                end else begin
                    m_discard = 1;
                end
            end
        end else begin
            if (m_owed && rv) begin
                if (!m_discard) begin
                    q.push_back('{pc: m_req_pc + PC_STEP, ins: rd});
                    m_fetched = m_fetched + 32'd1;
                end
                m_owed    = 0;
                m_discard = 0;
            end
            if (was_valid && !f) begin
                void'(q.pop_front());
            end
            if (exp_req) begin
                m_owed   = 1;
                m_req_pc = m_fpc;
                m_fpc    = m_fpc + PC_STEP;
            end
        end

        // Memory update: a response owed across a reset arrives right after it.
        if (rv) begin
            pend = 0;
        end else if (pend) begin
            wcnt--;
        end
        if (!r && pend) begin
            wcnt = 0;
        end
        if (exp_req) begin
            pend      = 1;
            wcnt      = $urandom_range(0, 3);
            pend_data = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] a;
        a = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 7) == 0) begin
            a = 32'hFFFF_FFF4;
        end
        return a;
    endfunction

    initial begin
        n_chk     = 0;
        n_err     = 0;
        armed     = 0;
        pend      = 0;
        wcnt      = 0;
        pend_data = '0;
        m_owed    = 0;
        m_discard = 0;
        m_fpc     = RESET_PC;
        m_req_pc  = '0;
        m_fetched = '0;
        m_flushed = '0;

        // Reset, then check the reset state while still in reset.
        cycle(0, 0, 0, 32'h0);
        armed = 1;
        cycle(0, 0, 0, 32'h0);

        // Free-running fetch, no stalls.
        repeat (40) cycle(1, 0, 0, 32'h0);

        // Hold the head until the queue is full, then drain.
        repeat (30) cycle(1, 1, 0, 32'h0);
        repeat (30) cycle(1, 0, 0, 32'h0);

        // Branch to 0x100 and let the pipeline refill.
        cycle(1, 0, 1, 32'h0000_0100);
        repeat (20) cycle(1, 0, 0, 32'h0);

        // Fill under freeze, then flush with a full queue.
        repeat (20) cycle(1, 1, 0, 32'h0);
        cycle(1, 1, 1, 32'h0000_0200);
        repeat (20) cycle(1, 0, 0, 32'h0);

        // Frequent branches and stalls.
        for (int i = 0; i < 400; i++) begin
            cycle(1, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, rand_target());
        end

        // Everything mixed, including resets with responses in flight.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 49) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  rand_target());
        end

        // Long stall phase with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            cycle(1, $urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0, rand_target());
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
